fm_tx_sequencer: RTL and testbench

FM_TX_SEQUENCER -- requirements
Module: fm_tx_sequencer

---
 rtl/fm_tx_sequencer_if.sv | 10 +
 rtl/fm_tx_sequencer.sv | 71 +++++++
 tb/tb_fm_tx_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fm_tx_sequencer_if.sv
// fm_tx_sequencer_if: sample intake handshake and modulator strobe bus
interface fm_tx_sequencer_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] mod_data;
  logic             mod_stb;
  modport master (output s_data, s_valid, input s_ready, mod_data, mod_stb);
  modport slave (input s_data, s_valid, output s_ready, mod_data, mod_stb);
endinterface

// File: rtl/fm_tx_sequencer.sv
// fm_tx_sequencer: buffers audio samples and paces them to an FM modulator at FS_IN
module fm_tx_sequencer #(
  parameter int WIDTH       = 16,
  parameter int FCLK        = 48000000,
  parameter int FS_IN       = 48000,
  parameter int DEPTH       = 8,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  fm_tx_sequencer_if.slave         bus,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              underrun_cnt
);
  localparam int DIV = FCLK / FS_IN;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} st_t;
  st_t              st;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, active, tick, pop, push, flush;
  assign state        = st;
  assign full         = level == LW'(DEPTH);
  assign active       = st == RUN || st == DRAIN;
  assign tick         = active && cnt == CW'(DIV - 1);
  assign pop          = tick && level != '0;
  assign bus.s_ready  = !full && (st == PRIME || st == RUN);
  assign push         = bus.s_valid && bus.s_ready;
  assign flush        = st == PRIME && stop;
  // sample storage; a push only lands at the edge, so it cannot be popped in the same cycle
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.s_data;
  // FIFO pointers and occupancy; aborting a prime discards everything queued
  always_ff @(posedge clk)
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  // control FSM, pacing counter and registered modulator outputs
  always_ff @(posedge clk)
    if (rst) begin
      st           <= IDLE;
      cnt          <= '0;
      bus.mod_data <= '0;
      bus.mod_stb  <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      unique case (st)
        IDLE:    if (start && !stop) st <= PRIME;
        PRIME:   if (stop) st <= IDLE; else if (level >= LW'(PRIME_LEVEL)) st <= RUN;
        RUN:     if (stop) st <= DRAIN;
        DRAIN:   if (tick && !pop) st <= IDLE;
        default: st <= IDLE;
      endcase
      cnt         <= active ? (tick ? '0 : cnt + 1'b1) : '0;
      bus.mod_stb <= tick;
      if (tick) bus.mod_data <= pop ? mem[rd_ptr] : '0;
      if (tick && !pop && st == RUN && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
    end
endmodule

// File: tb/tb_fm_tx_sequencer.sv
// tb_fm_tx_sequencer: directed checks of priming, pacing, underrun, full, drain, abort and reset
module tb_fm_tx_sequencer;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic        stop = 0;
  logic [1:0]  state;
  logic [3:0]  level;
  logic [15:0] underrun_cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  fm_tx_sequencer_if #(.WIDTH(16)) bus ();
  fm_tx_sequencer #(.WIDTH(16), .FCLK(1000), .FS_IN(100), .DEPTH(8), .PRIME_LEVEL(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .bus(bus),
    .state(state), .level(level), .underrun_cnt(underrun_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_stb(output int k);
    k = 0;
    do begin
      cycle();
      k++;
    end while (!bus.mod_stb && k < 100);
    if (!bus.mod_stb) chk("stb_timeout", 0, 1);
  endtask
  task automatic count_stb(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (bus.mod_stb) c++;
    end
  endtask
  initial begin
    int k, c, v, max_lvl;
    bit acc, full_seen;
    logic [15:0] got[$];
    bus.s_data = '0;
    bus.s_valid = 0;
    cycle();
    cycle();
    chk("rst_state", state, 0);
    chk("rst_level", level, 0);
    chk("rst_stb", bus.mod_stb, 0);
    chk("rst_data", bus.mod_data, 0);
    chk("rst_ur", underrun_cnt, 0);
    chk("rst_rdy", bus.s_ready, 0);
    rst = 0;
    cycle();
    chk("idle_rdy", bus.s_ready, 0);
    start = 1;
    cycle();
    start = 0;
    chk("prime_state", state, 1);
    chk("prime_rdy", bus.s_ready, 1);
    for (int i = 1; i <= 4; i++) begin
      bus.s_valid = 1;
      bus.s_data = 16'(i);
      cycle();
    end
    bus.s_valid = 0;
    chk("prime_lvl4", level, 4);
    chk("prime_still", state, 1);
    cycle();
    chk("run_entry", state, 2);
    for (int i = 1; i <= 4; i++) begin
      wait_stb(k);
      chk($sformatf("play_gap%0d", i), k, 10);
      chk($sformatf("play_data%0d", i), bus.mod_data, i);
    end
    wait_stb(k);
    chk("ur1_gap", k, 10);
    chk("ur1_data", bus.mod_data, 0);
    chk("ur1_cnt", underrun_cnt, 1);
    wait_stb(k);
    chk("ur2_cnt", underrun_cnt, 2);
    v = 10;
    bus.s_valid = 1;
    bus.s_data = 16'(v);
    full_seen = 0;
    max_lvl = 0;
    for (int i = 0; i < 400 && got.size() < 8; i++) begin
      acc = bus.s_valid && bus.s_ready;
      cycle();
      if (acc) v++;
      if (v > 20) bus.s_valid = 0;
      else bus.s_data = 16'(v);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (level == 8 && !full_seen) begin
        chk("full_rdy", bus.s_ready, 0);
        full_seen = 1;
      end
      if (bus.mod_stb) got.push_back(bus.mod_data);
    end
    chk("full_seen", full_seen, 1);
    chk("full_max", max_lvl, 8);
    chk("full_pushed", v, 21);
    chk("full_nstb", got.size(), 8);
    for (int i = 0; i < got.size(); i++) chk($sformatf("full_data%0d", i), got[i], 10 + i);
    chk("drain_q", level, 3);
    stop = 1;
    cycle();
    stop = 0;
    chk("drain_state", state, 3);
    chk("drain_rdy", bus.s_ready, 0);
    for (int i = 0; i < 3; i++) begin
      wait_stb(k);
      chk($sformatf("drain_data%0d", i), bus.mod_data, 18 + i);
      chk($sformatf("drain_st%0d", i), state, 3);
    end
    wait_stb(k);
    chk("drain_last", bus.mod_data, 0);
    chk("drain_idle", state, 0);
    chk("drain_ur", underrun_cnt, 2);
    chk("drain_lvl", level, 0);
    start = 1;
    stop = 1;
    cycle();
    start = 0;
    stop = 0;
    chk("idle_both", state, 0);
    start = 1;
    cycle();
    start = 0;
    chk("abort_prime", state, 1);
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1;
      bus.s_data = 16'(40 + i);
      cycle();
    end
    bus.s_valid = 0;
    chk("abort_lvl2", level, 2);
    start = 1;
    stop = 1;
    cycle();
    start = 0;
    stop = 0;
    chk("abort_state", state, 0);
    chk("abort_lvl", level, 0);
    count_stb(15, c);
    chk("abort_nostb", c, 0);
    chk("abort_stay", state, 0);
    chk("persist_ur", underrun_cnt, 2);
    start = 1;
    cycle();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1;
      bus.s_data = 16'(30 + i);
      cycle();
    end
    bus.s_valid = 0;
    chk("mid_lvl5", level, 5);
    chk("mid_run", state, 2);
    rst = 1;
    cycle();
    rst = 0;
    chk("mid_state", state, 0);
    chk("mid_level", level, 0);
    chk("mid_stb", bus.mod_stb, 0);
    chk("mid_data", bus.mod_data, 0);
    chk("mid_ur", underrun_cnt, 0);
    chk("mid_rdy", bus.s_ready, 0);
    count_stb(30, c);
    chk("mid_nostb", c, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
